alu_sequencer: RTL

//  Control-side end of the ALU interface. Accepts one ALU operation request,

---
 rtl/alu_sequencer_pkg.sv | 63 ++++++
 rtl/alu_op_decode.sv | 95 +++++++++
 rtl/alu_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - shared op codes, flag indices, FSM states and strobe struct for the ALU sequencer
package alu_sequencer_pkg;

    // Operation codes presented by the instruction decoder
    localparam logic [3:0] OP_ADC = 4'd0;
    localparam logic [3:0] OP_SBC = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_ORA = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_ASL = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;
    localparam logic [3:0] OP_LSR = 4'd8;
    localparam logic [3:0] OP_ROR = 4'd9;
    localparam logic [3:0] OP_INC = 4'd10;

    // Bit positions inside the {N,Z,C,V} flag and write-mask vectors
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Status-register write masks used by the op table
    localparam logic [3:0] WE_NZCV = 4'b1111;
    localparam logic [3:0] WE_NZC  = 4'b1110;
    localparam logic [3:0] WE_NZ   = 4'b1100;
    localparam logic [3:0] WE_NONE = 4'b0000;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // ALU input-load and operation-select strobes, in output port order
    typedef struct packed {
        logic db_n_add;
        logic db_add;
        logic adl_add;
        logic zero_add;
        logic sb_add;
        logic one_addc;
        logic sums;
        logic ands;
        logic eors;
        logic ors;
        logic srs;
    } strobes_t;

    // Status flags derived from the sampled ALU outputs
    function automatic logic [3:0] flags_of(input logic [7:0] add, input logic acr, input logic avr);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = add[7];
        f[FLAG_Z] = (add == 8'h00);
        f[FLAG_C] = acr;
        f[FLAG_V] = avr;
        return f;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational op/carry to ALU strobe vector and flag write mask
module alu_op_decode
    import alu_sequencer_pkg::*;
(
    input  logic [3:0] i_op,
    input  logic       i_carry,
    output strobes_t   o_strobes,
    output logic [3:0] o_flag_we
);

    // Op table: which ALU inputs load, which function runs, carry-in, and which flags update
    always_comb begin
        o_strobes = '0;
        o_flag_we = WE_NONE;
        case (i_op)
            OP_ADC: begin
                o_strobes.sb_add   = 1'b1;
                o_strobes.db_add   = 1'b1;
                o_strobes.sums     = 1'b1;
                o_strobes.one_addc = i_carry;
                o_flag_we          = WE_NZCV;
            end
            OP_SBC: begin
                o_strobes.sb_add   = 1'b1;
                o_strobes.db_n_add = 1'b1;
                o_strobes.sums     = 1'b1;
                o_strobes.one_addc = i_carry;
                o_flag_we          = WE_NZCV;
            end
            OP_AND: begin
                o_strobes.sb_add = 1'b1;
                o_strobes.db_add = 1'b1;
                o_strobes.ands   = 1'b1;
                o_flag_we        = WE_NZ;
            end
            OP_ORA: begin
                o_strobes.sb_add = 1'b1;
                o_strobes.db_add = 1'b1;
                o_strobes.ors    = 1'b1;
                o_flag_we        = WE_NZ;
            end
            OP_EOR: begin
                o_strobes.sb_add = 1'b1;
                o_strobes.db_add = 1'b1;
                o_strobes.eors   = 1'b1;
                o_flag_we        = WE_NZ;
            end
            OP_CMP: begin
                // Compare is a subtract with forced carry-in; the stored carry is irrelevant
                o_strobes.sb_add   = 1'b1;
                o_strobes.db_n_add = 1'b1;
                o_strobes.sums     = 1'b1;
                o_strobes.one_addc = 1'b1;
                o_flag_we          = WE_NZC;
            end
            OP_ASL: begin
                // Shift left is A+A; the decoder puts the same value on SB and DB
                o_strobes.sb_add = 1'b1;
                o_strobes.db_add = 1'b1;
                o_strobes.sums   = 1'b1;
                o_flag_we        = WE_NZC;
            end
            OP_ROL: begin
                o_strobes.sb_add   = 1'b1;
                o_strobes.db_add   = 1'b1;
                o_strobes.sums     = 1'b1;
                o_strobes.one_addc = i_carry;
                o_flag_we          = WE_NZC;
            end
            OP_LSR: begin
                o_strobes.sb_add = 1'b1;
                o_strobes.srs    = 1'b1;
                o_flag_we        = WE_NZC;
            end
            OP_ROR: begin
                o_strobes.sb_add   = 1'b1;
                o_strobes.srs      = 1'b1;
                o_strobes.one_addc = i_carry;
                o_flag_we          = WE_NZC;
            end
            OP_INC: begin
                o_strobes.zero_add = 1'b1;
                o_strobes.db_add   = 1'b1;
                o_strobes.sums     = 1'b1;
                o_strobes.one_addc = 1'b1;
                o_flag_we          = WE_NZ;
            end
            default: begin
                o_strobes = '0;
                o_flag_we = WE_NONE;
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - sequences one ALU operation and returns result, NZCV flags and write mask
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int ALU_LATENCY = 1
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_start,
    input  logic [3:0] i_op,
    input  logic       i_carry,
    input  logic [7:0] i_add,
    input  logic       i_acr,
    input  logic       i_avr,
    output logic       o_db_n_add,
    output logic       o_db_add,
    output logic       o_adl_add,
    output logic       o_0_add,
    output logic       o_sb_add,
    output logic       o_1_addc,
    output logic       o_sums,
    output logic       o_ands,
    output logic       o_eors,
    output logic       o_ors,
    output logic       o_srs,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_result,
    output logic [3:0] o_flags,
    output logic [3:0] o_flag_we
);

    // WAIT counts down from LATENCY-1 to 0; the zero cycle is the capture cycle
    localparam logic [2:0] WAIT_LOAD = 3'(ALU_LATENCY - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] op_q, op_d;
    logic       carry_q, carry_d;
    strobes_t   strobes_q, strobes_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] result_q, result_d;
    logic [3:0] flags_q, flags_d;
    logic [3:0] we_q, we_d;

    strobes_t   dec_strobes;
    logic [3:0] dec_we;

    // The decoder looks at the op being latched this edge so strobes can be registered into EXEC
    alu_op_decode u_decode (
        .i_op      (op_d),
        .i_carry   (carry_d),
        .o_strobes (dec_strobes),
        .o_flag_we (dec_we)
    );

    // Next state, request latch, wait counter and result/flag capture
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        carry_d  = carry_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_d = ST_EXEC;
                    op_d    = i_op;
                    carry_d = i_carry;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_d = ST_WAIT;
                cnt_d   = WAIT_LOAD;
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d  = ST_DONE;
                    result_d = i_add;
                    flags_d  = flags_of(i_add, i_acr, i_avr);
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decided from the next state so they are registered yet aligned to that state
    always_comb begin
        strobes_d = '0;
        we_d      = WE_NONE;
        busy_d    = (state_d == ST_EXEC) || (state_d == ST_WAIT);
        done_d    = (state_d == ST_DONE);
        if (state_d == ST_EXEC) begin
            strobes_d = dec_strobes;
        end
        if (state_d == ST_DONE) begin
            we_d = dec_we;
        end
    end

    // State and registered outputs; reset abandons any operation in flight
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            op_q      <= 4'd0;
            carry_q   <= 1'b0;
            strobes_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= 8'h00;
            flags_q   <= 4'b0000;
            we_q      <= WE_NONE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            carry_q   <= carry_d;
            strobes_q <= strobes_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            we_q      <= we_d;
        end
    end

    assign o_db_n_add = strobes_q.db_n_add;
    assign o_db_add   = strobes_q.db_add;
    assign o_adl_add  = strobes_q.adl_add;
    assign o_0_add    = strobes_q.zero_add;
    assign o_sb_add   = strobes_q.sb_add;
    assign o_1_addc   = strobes_q.one_addc;
    assign o_sums     = strobes_q.sums;
    assign o_ands     = strobes_q.ands;
    assign o_eors     = strobes_q.eors;
    assign o_ors      = strobes_q.ors;
    assign o_srs      = strobes_q.srs;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_result   = result_q;
    assign o_flags    = flags_q;
    assign o_flag_we  = we_q;

endmodule
